// File: rtl/sc_mir_buffer.sv
// sc_mir_buffer
// -----------------------------------------------------------------------------
// Microinstruction register with a two-entry skid buffer. It sits between the
// control store and the datapath, so the control unit can keep fetching while
// the datapath stalls. It also counts issued microwords and, optionally, checks
// the parity of every incoming word.
//
// Optional feature macro: SC_MIRBUF_PARITY_EN
//   defined   - each accepted word is checked for even parity. A bad word is
//               stored as an all-zero NOP, still marked valid, and the sticky
//               ParityErr flag is set until reset.
//   undefined - parity_In is ignored and ParityErr_Out is tied to 0.
//
// Handshake:
//   The control-store side uses valid/ready. A word transfers on a rising edge
//   where valid_In and ready_Out are both 1. ready_Out comes from a register
//   only (it is NOT skid_valid), so it never depends on valid_In or hold in the
//   same cycle. While valid_In is high, data_InBUS and parity_In must be stable.
//   The datapath side consumes the word on OUT on every edge where valid_Out=1
//   and hold_InHigh=0.
//
// Ports:
//   SC_MIRBUF_CLOCK_50          clock, all state changes on its rising edge
//   SC_MIRBUF_RESET_InHigh      synchronous active-high reset (beats flush)
//   SC_MIRBUF_clear_InLow       synchronous active-low flush of both entries
//   SC_MIRBUF_data_InBUS        microword from the control store
//   SC_MIRBUF_parity_In         even-parity bit over data_InBUS
//   SC_MIRBUF_valid_In          data_InBUS is valid
//   SC_MIRBUF_ready_Out         buffer can accept a microword
//   SC_MIRBUF_hold_InHigh       datapath stall, the OUT word is not consumed
//   SC_MIRBUF_valid_Out         field outputs hold a live microword
//   SC_MIRBUF_*_Out/_OutBUS     microword fields. All are zero when valid_Out=0
//   SC_MIRBUF_IssueCount_OutBUS number of consumed microwords, wraps
//   SC_MIRBUF_ParityErr_Out     sticky parity-error flag
// -----------------------------------------------------------------------------
module sc_mir_buffer #(
    parameter int REG_AW  = 6,
    parameter int ALU_W   = 4,
    parameter int COND_W  = 3,
    parameter int JADDR_W = 11,
    parameter int CNT_W   = 16,
    localparam int MIR_DATAWIDTH = 3*REG_AW + ALU_W + COND_W + JADDR_W + 5
) (
    input  logic                     SC_MIRBUF_CLOCK_50,
    input  logic                     SC_MIRBUF_RESET_InHigh,
    input  logic                     SC_MIRBUF_clear_InLow,
    input  logic [MIR_DATAWIDTH-1:0] SC_MIRBUF_data_InBUS,
    input  logic                     SC_MIRBUF_parity_In,
    input  logic                     SC_MIRBUF_valid_In,
    output logic                     SC_MIRBUF_ready_Out,
    input  logic                     SC_MIRBUF_hold_InHigh,
    output logic                     SC_MIRBUF_valid_Out,
    output logic [REG_AW-1:0]        SC_MIRBUF_A_OutBUS,
    output logic                     SC_MIRBUF_AMUX_Out,
    output logic [REG_AW-1:0]        SC_MIRBUF_B_OutBUS,
    output logic                     SC_MIRBUF_BMUX_Out,
    output logic [REG_AW-1:0]        SC_MIRBUF_C_OutBUS,
    output logic                     SC_MIRBUF_CMUX_Out,
    output logic                     SC_MIRBUF_Read_Out,
    output logic                     SC_MIRBUF_Write_Out,
    output logic [ALU_W-1:0]         SC_MIRBUF_ALU_OutBUS,
    output logic [COND_W-1:0]        SC_MIRBUF_Cond_OutBUS,
    output logic [JADDR_W-1:0]       SC_MIRBUF_JumpAddr_OutBUS,
    output logic [CNT_W-1:0]         SC_MIRBUF_IssueCount_OutBUS,
    output logic                     SC_MIRBUF_ParityErr_Out
);

    // Field positions, packed MSB to LSB:
    // A, AMUX, B, BMUX, C, CMUX, Read, Write, ALU, Cond, JumpAddr
    localparam int JADDR_LSB = 0;
    localparam int COND_LSB  = JADDR_LSB + JADDR_W;
    localparam int ALU_LSB   = COND_LSB + COND_W;
    localparam int WRITE_BIT = ALU_LSB + ALU_W;
    localparam int READ_BIT  = WRITE_BIT + 1;
    localparam int CMUX_BIT  = READ_BIT + 1;
    localparam int C_LSB     = CMUX_BIT + 1;
    localparam int BMUX_BIT  = C_LSB + REG_AW;
    localparam int B_LSB     = BMUX_BIT + 1;
    localparam int AMUX_BIT  = B_LSB + REG_AW;
    localparam int A_LSB     = AMUX_BIT + 1;

    logic [MIR_DATAWIDTH-1:0] outData;
    logic                     outValid;
    logic [MIR_DATAWIDTH-1:0] skidData;
    logic                     skidValid;
    logic [CNT_W-1:0]         issueCount;

    logic                     accept;
    logic                     consume;
    logic                     outAdvance;
    logic [MIR_DATAWIDTH-1:0] storeWord;
    logic                     parityBad;

    assign SC_MIRBUF_ready_Out = ~skidValid;
    assign accept     = SC_MIRBUF_valid_In & ~skidValid;
    assign consume    = outValid & ~SC_MIRBUF_hold_InHigh;
    assign outAdvance = ~outValid | consume;

`ifdef SC_MIRBUF_PARITY_EN
    logic parityErr;

    // Even parity: the parity bit XOR all data bits must be 0.
    assign parityBad = SC_MIRBUF_parity_In ^ (^SC_MIRBUF_data_InBUS);
    // A corrupted word becomes a NOP, but it still flows through the handshake.
    assign storeWord = parityBad ? '0 : SC_MIRBUF_data_InBUS;
    assign SC_MIRBUF_ParityErr_Out = parityErr;

    always_ff @(posedge SC_MIRBUF_CLOCK_50) begin
        if (SC_MIRBUF_RESET_InHigh) begin
            parityErr <= 1'b0;
        end else if (SC_MIRBUF_clear_InLow && accept && parityBad) begin
            parityErr <= 1'b1;
        end
    end
`else
    logic unusedParity;

    assign unusedParity = SC_MIRBUF_parity_In;
    assign parityBad    = 1'b0;
    assign storeWord    = SC_MIRBUF_data_InBUS;
    assign SC_MIRBUF_ParityErr_Out = 1'b0;
`endif

    always_ff @(posedge SC_MIRBUF_CLOCK_50) begin
        if (SC_MIRBUF_RESET_InHigh) begin
            outData    <= '0;
            outValid   <= 1'b0;
            skidData   <= '0;
            skidValid  <= 1'b0;
            issueCount <= '0;
        end else if (!SC_MIRBUF_clear_InLow) begin
            // Flush drops both entries and any offered word. The count is kept.
            outData   <= '0;
            outValid  <= 1'b0;
            skidData  <= '0;
            skidValid <= 1'b0;
        end else begin
            if (consume) begin
                issueCount <= issueCount + CNT_W'(1);
            end
            if (outAdvance) begin
                if (skidValid) begin
                    // ready_Out is low here, so accept cannot also be 1.
                    outData   <= skidData;
                    outValid  <= 1'b1;
                    skidData  <= '0;
                    skidValid <= 1'b0;
                end else if (accept) begin
                    outData  <= storeWord;
                    outValid <= 1'b1;
                end else begin
                    // Zero the data so a dead slot never drives Read/Write.
                    outData  <= '0;
                    outValid <= 1'b0;
                end
            end else if (accept) begin
                skidData  <= storeWord;
                skidValid <= 1'b1;
            end
        end
    end

    assign SC_MIRBUF_valid_Out         = outValid;
    assign SC_MIRBUF_A_OutBUS          = outData[A_LSB +: REG_AW];
    assign SC_MIRBUF_AMUX_Out          = outData[AMUX_BIT];
    assign SC_MIRBUF_B_OutBUS          = outData[B_LSB +: REG_AW];
    assign SC_MIRBUF_BMUX_Out          = outData[BMUX_BIT];
    assign SC_MIRBUF_C_OutBUS          = outData[C_LSB +: REG_AW];
    assign SC_MIRBUF_CMUX_Out          = outData[CMUX_BIT];
    assign SC_MIRBUF_Read_Out          = outData[READ_BIT];
    assign SC_MIRBUF_Write_Out         = outData[WRITE_BIT];
    assign SC_MIRBUF_ALU_OutBUS        = outData[ALU_LSB +: ALU_W];
    assign SC_MIRBUF_Cond_OutBUS       = outData[COND_LSB +: COND_W];
    assign SC_MIRBUF_JumpAddr_OutBUS   = outData[JADDR_LSB +: JADDR_W];
    assign SC_MIRBUF_IssueCount_OutBUS = issueCount;

endmodule

// File: tb/tb_sc_mir_buffer.sv
// Testbench for sc_mir_buffer. The issue counter is instantiated 4 bits wide
// so that wrap-around is reachable. The driver keeps a queue model of the
// two-entry buffer and pushes every expected word into exp_q. A monitor on the
// falling edge compares the presented word and pops it on consume.
module tb_sc_mir_buffer;

    localparam int W     = 41;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             clr_n;
    logic [W-1:0]     din;
    logic             par;
    logic             vin;
    logic             rdy;
    logic             hold;
    logic             vout;
    logic [5:0]       a_f, b_f, c_f;
    logic             amux, bmux, cmux, rd, wr;
    logic [3:0]       alu;
    logic [2:0]       cond;
    logic [10:0]      jaddr;
    logic [CNT_W-1:0] cnt;
    logic             perr;

    sc_mir_buffer #(.CNT_W(CNT_W)) dut (
        .SC_MIRBUF_CLOCK_50          (clk),
        .SC_MIRBUF_RESET_InHigh      (rst),
        .SC_MIRBUF_clear_InLow       (clr_n),
        .SC_MIRBUF_data_InBUS        (din),
        .SC_MIRBUF_parity_In         (par),
        .SC_MIRBUF_valid_In          (vin),
        .SC_MIRBUF_ready_Out         (rdy),
        .SC_MIRBUF_hold_InHigh       (hold),
        .SC_MIRBUF_valid_Out         (vout),
        .SC_MIRBUF_A_OutBUS          (a_f),
        .SC_MIRBUF_AMUX_Out          (amux),
        .SC_MIRBUF_B_OutBUS          (b_f),
        .SC_MIRBUF_BMUX_Out          (bmux),
        .SC_MIRBUF_C_OutBUS          (c_f),
        .SC_MIRBUF_CMUX_Out          (cmux),
        .SC_MIRBUF_Read_Out          (rd),
        .SC_MIRBUF_Write_Out         (wr),
        .SC_MIRBUF_ALU_OutBUS        (alu),
        .SC_MIRBUF_Cond_OutBUS       (cond),
        .SC_MIRBUF_JumpAddr_OutBUS   (jaddr),
        .SC_MIRBUF_IssueCount_OutBUS (cnt),
        .SC_MIRBUF_ParityErr_Out     (perr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst   = 1'b1;
        clr_n = 1'b1;
        din   = '0;
        par   = 1'b0;
        vin   = 1'b1;
        hold  = 1'b0;
    end

    // ---------------- checking state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model: buffer contents as a plain FIFO of at most two words.
    logic [W-1:0]     mq[$];
    logic [CNT_W-1:0] m_cnt  = '0;
    logic             m_perr = 1'b0;
    // Model view of the state the DUT holds during the current cycle.
    logic             s_init  = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready = 1'b1;
    logic [CNT_W-1:0] s_cnt   = '0;
    logic             s_perr  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] stored_word(input logic [W-1:0] d, input logic p);
`ifdef SC_MIRBUF_PARITY_EN
        return (p ^ (^d)) ? '0 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic bad_parity(input logic [W-1:0] d, input logic p);
`ifdef SC_MIRBUF_PARITY_EN
        return p ^ (^d);
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: drive inputs after the rising edge, then advance the
    // model by the effect of the next rising edge. 'acc' reports acceptance.
    task automatic step(input logic v, input logic [W-1:0] d, input logic p,
                        input logic h, input logic c_n, input logic r,
                        output logic acc);
        logic cons;
        @(posedge clk);
        #1;
        s_init  = 1'b1;
        s_valid = (mq.size() > 0);
        s_ready = (mq.size() < 2);
        s_cnt   = m_cnt;
        s_perr  = m_perr;
        vin   = v;
        din   = d;
        par   = p;
        hold  = h;
        clr_n = c_n;
        rst   = r;
        acc   = 1'b0;
        if (r) begin
            mq.delete();
            m_cnt  = '0;
            m_perr = 1'b0;
        end else if (!c_n) begin
            mq.delete();
        end else begin
            cons = (mq.size() > 0) && !h;
            acc  = v && (mq.size() < 2);
            if (cons) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (acc) begin
                mq.push_back(stored_word(d, p));
                exp_q.push_back(stored_word(d, p));
                if (bad_parity(d, p)) m_perr = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic h);
        logic acc;
        step(1'b0, '0, 1'b0, h, 1'b1, 1'b0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b1, {W{1'b1}}, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, {W{1'b1}}, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    endtask

    // Offer a good-parity word until the model says it was accepted.
    task automatic send(input logic [W-1:0] d, input logic h);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            step(1'b1, d, ^d, h, 1'b1, 1'b0, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) chk("send_timeout", 64'(tries), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        got = {a_f, amux, b_f, bmux, c_f, cmux, rd, wr, alu, cond, jaddr};
        if (s_init) begin
            chk("valid_out", 64'(vout), 64'(s_valid));
            chk("ready_out", 64'(rdy), 64'(s_ready));
            chk("issue_count", 64'(cnt), 64'(s_cnt));
            chk("parity_err", 64'(perr), 64'(s_perr));
            if (vout) begin
                if (exp_q.size() == 0) chk("word_unexpected", 64'(got), 64'd0);
                else chk("word", 64'(got), 64'(exp_q[0]));
            end else begin
                chk("dead_fields_zero", 64'(got), 64'd0);
            end
            if (rst || !clr_n) exp_q.delete();
            else if (vout && !hold && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        logic [W-1:0] bad_w;
        logic         acc;

        // Reset with valid_In held high.
        do_reset();
        idle(1'b0);
        @(negedge clk);
        chk("reset_valid", 64'(vout), 64'd0);
        chk("reset_ready", 64'(rdy), 64'd1);
        chk("reset_count", 64'(cnt), 64'd0);

        // Streaming: 8 back-to-back words, one word is 0x1F8_0000_0000.
        for (int i = 0; i < 10; i++) begin
            w = 41'h155_5555_5555 ^ (41'(i) << (4 * i));
            if (i == 3) w = 41'h1F8_0000_0000;
            if (i < 8) step(1'b1, w, ^w, 1'b0, 1'b1, 1'b0, acc);
            else idle(1'b0);
            if (i == 4) begin
                @(negedge clk);
                chk("a_field_3f", 64'(a_f), 64'h3F);
            end
        end
        @(negedge clk);
        chk("stream_count_8", 64'(cnt), 64'd8);

        // Stall: W1 held in OUT, W2 in SKID, W3 offered until accepted.
        send(41'h0AA_1111_2222, 1'b0);
        send(41'h0BB_3333_4444, 1'b1);
        step(1'b1, 41'h0CC_5555_6666, ^41'h0CC_5555_6666, 1'b1, 1'b1, 1'b0, acc);
        @(negedge clk);
        chk("skid_full_ready", 64'(rdy), 64'd0);
        chk("w3_not_accepted", 64'(acc), 64'd0);
        step(1'b1, 41'h0CC_5555_6666, ^41'h0CC_5555_6666, 1'b1, 1'b1, 1'b0, acc);
        send(41'h0CC_5555_6666, 1'b0);
        repeat (3) idle(1'b0);

        // Flush with both entries full and count 5, word offered and OUT consumable.
        do_reset();
        for (int i = 0; i < 5; i++) send(W'($urandom) ^ (W'($urandom) << 32), 1'b0);
        idle(1'b0);
        send(41'h1AB_CDEF_0123, 1'b1);
        send(41'h045_6789_ABCD, 1'b1);
        step(1'b1, 41'h111_1111_1111, ^41'h111_1111_1111, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        chk("pre_flush_ready", 64'(rdy), 64'd0);
        chk("pre_flush_count", 64'(cnt), 64'd5);
        idle(1'b0);
        @(negedge clk);
        chk("flush_valid", 64'(vout), 64'd0);
        chk("flush_ready", 64'(rdy), 64'd1);
        chk("flush_count", 64'(cnt), 64'd5);
        chk("flush_fields", 64'({a_f, amux, b_f, bmux, c_f, cmux, rd, wr, alu, cond, jaddr}), 64'd0);

        // Counter wrap: 17 consumes on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) send(41'h100_0000_0000 | W'(i), 1'b0);
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("wrap_count_1", 64'(cnt), 64'd1);

        // Parity: a word with wrong parity, then flush, then reset.
        bad_w = 41'h0F0_F0F0_F0F1;
        step(1'b1, bad_w, ~(^bad_w), 1'b0, 1'b1, 1'b0, acc);
        idle(1'b1);
        @(negedge clk);
        chk("par_valid", 64'(vout), 64'd1);
`ifdef SC_MIRBUF_PARITY_EN
        chk("par_nop", 64'({a_f, amux, b_f, bmux, c_f, cmux, rd, wr, alu, cond, jaddr}), 64'd0);
        chk("par_err_set", 64'(perr), 64'd1);
`else
        chk("par_ignored", 64'({a_f, amux, b_f, bmux, c_f, cmux, rd, wr, alu, cond, jaddr}), 64'(bad_w));
        chk("par_err_tied", 64'(perr), 64'd0);
`endif
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(1'b0);
        @(negedge clk);
`ifdef SC_MIRBUF_PARITY_EN
        chk("par_err_sticky", 64'(perr), 64'd1);
`else
        chk("par_err_tied2", 64'(perr), 64'd0);
`endif
        do_reset();
        idle(1'b0);
        @(negedge clk);
        chk("par_err_reset", 64'(perr), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic         v, h, cn, r, p;
            logic [W-1:0] d;
            d  = {W'($urandom) << 32} | W'($urandom);
            v  = ($urandom_range(0, 99) < 70);
            h  = ($urandom_range(0, 99) < 30);
            cn = !($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 199) < 1);
            p  = ($urandom_range(0, 99) < 5) ? ~(^d) : ^d;
            step(v, d, p, h, cn, r, acc);
        end

        // Drain and confirm nothing was lost.
        repeat (4) idle(1'b0);
        @(negedge clk);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
